// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end and datapath: widths,
// command-issuer FSM states and the datapath opcode encodings.
package calc_pkg;

  localparam int OPD_W = 3;
  localparam int OPC_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_AND = 2'd2,
    OPC_OR  = 2'd3
  } opcode_t;

  // Counter width for a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_cmd_issuer_if.sv
// Board-side inputs and datapath-side Go/Done signals of the command issuer.
interface calc_cmd_issuer_if;
  import calc_pkg::*;

  logic             go_raw;
  logic [OPC_W-1:0] op_sw;
  logic [OPD_W-1:0] in1_sw;
  logic [OPD_W-1:0] in2_sw;
  logic             done;
  logic             go;
  logic [OPC_W-1:0] op;
  logic [OPD_W-1:0] in1;
  logic [OPD_W-1:0] in2;
  logic             busy;
  logic             err;

  // go is a one-cycle strobe; op/in1/in2 are valid from go until the next
  // accepted press. The command completes on a rising edge of the done level.
  modport master (
    output go_raw, op_sw, in1_sw, in2_sw, done,
    input  go, op, in1, in2, busy, err
  );

  modport slave (
    input  go_raw, op_sw, in1_sw, in2_sw, done,
    output go, op, in1, in2, busy, err
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a level debouncer: the output level only
// follows the input after DB_CYCLES consecutive cycles of disagreement.
module sync_debounce
  import calc_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = r_sync ^ r_level;
  assign w_flip = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  // The counter never passes CNT_LAST: reaching it either flips the level or
  // the run of disagreement has already been broken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_level <= r_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_flip & r_sync;

endmodule

// File: rtl/calc_cmd_issuer.sv
// Calculator front end: debounced Go press -> snapshot of switches -> one go
// strobe to the datapath, then wait for done (with timeout) and a full release.
module calc_cmd_issuer
  import calc_pkg::*;
#(
  parameter int DB_CYCLES = 250000,
  parameter int TIMEOUT   = 1024
) (
  input  logic             clk50MHz,
  input  logic             rst,
  calc_cmd_issuer_if.slave bus,
  output state_t           o_dbg_state
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_db_level;
  logic             w_db_rise;
  logic             r_done_q;
  logic             w_done_rise;
  logic [TW-1:0]    r_to_cnt;
  logic             r_err;
  logic [OPC_W-1:0] r_op;
  logic [OPD_W-1:0] r_in1;
  logic [OPD_W-1:0] r_in2;
  logic             w_capture;
  logic             w_to_clr;
  logic             w_to_inc;
  logic             w_err_set;

  sync_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_sync_debounce (
    .i_clk   (clk50MHz),
    .i_rst_n (rst),
    .i_async (bus.go_raw),
    .o_level (w_db_level),
    .o_rise  (w_db_rise)
  );

  // done_q tracks done in every state, so a level already high on entry to
  // WAIT is never mistaken for a rising edge.
  assign w_done_rise = bus.done & ~r_done_q;

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_to_clr    = 1'b0;
    w_to_inc    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_db_rise) begin
          w_state_nxt = ST_ISSUE;
          w_capture   = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_to_clr    = 1'b1;
      end
      ST_WAIT: begin
        if (w_done_rise) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_RELEASE;
          w_err_set   = 1'b1;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!w_db_level) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50MHz or negedge rst) begin
    if (!rst) begin
      r_done_q <= 1'b0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
      r_op     <= '0;
      r_in1    <= '0;
      r_in2    <= '0;
    end else begin
      r_done_q <= bus.done;
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
      if (w_capture) begin
        r_err <= 1'b0;
        r_op  <= bus.op_sw;
        r_in1 <= bus.in1_sw;
        r_in2 <= bus.in2_sw;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.go      = (r_state == ST_ISSUE);
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.err     = r_err;
  assign bus.op      = r_op;
  assign bus.in1     = r_in1;
  assign bus.in2     = r_in2;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Bench for calc_cmd_issuer: directed scenarios plus random presses/done,
// checked every cycle against a behavioural model of the issuer.
module tb_calc_cmd_issuer;
  import calc_pkg::*;

  localparam int DB = 4;
  localparam int TO = 16;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_REL = 3;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc;
  state_t dbg_state;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  calc_cmd_issuer_if bus();

  calc_cmd_issuer #(
    .DB_CYCLES(DB),
    .TIMEOUT  (TO)
  ) dut (
    .clk50MHz    (clk),
    .rst         (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int go_count = 0;

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Go is accepted when the synchronised input (two clocks late) has disagreed
  // with the accepted level for DB consecutive cycles.
  int         m_mode;
  bit         m_lvl;
  bit         m_lvl_before;
  bit         m_all_diff;
  bit         m_rose;
  bit         m_done_prev;
  bit         m_done_rise;
  int         m_wait_cycles;
  bit         m_err;
  logic [1:0] m_op;
  logic [2:0] m_in1;
  logic [2:0] m_in2;
  bit         raw_hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] cmd_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_lvl = 1'b0;
      m_done_prev = 1'b0;
      m_wait_cycles = 0;
      m_err = 1'b0;
      m_op = '0;
      m_in1 = '0;
      m_in2 = '0;
      raw_hist.delete();
      for (int i = 0; i < DB + 2; i++) raw_hist.push_back(1'b0);
      exp_q.delete();
    end else begin
      m_lvl_before = m_lvl;
      raw_hist.push_back(bus.go_raw);
      void'(raw_hist.pop_front());
      m_all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (raw_hist[i] == m_lvl) m_all_diff = 1'b0;
      if (m_all_diff) m_lvl = ~m_lvl;
      m_rose = m_all_diff && m_lvl;
      m_done_rise = bus.done && !m_done_prev;
      m_done_prev = bus.done;
      case (m_mode)
        M_IDLE: if (m_rose) begin
          m_mode = M_ISSUE;
          m_op = bus.op_sw;
          m_in1 = bus.in1_sw;
          m_in2 = bus.in2_sw;
          m_err = 1'b0;
          exp_q.push_back({bus.op_sw, bus.in1_sw, bus.in2_sw});
        end
        M_ISSUE: begin
          m_mode = M_WAIT;
          m_wait_cycles = 0;
        end
        M_WAIT: if (m_done_rise) begin
          m_mode = M_REL;
        end else begin
          m_wait_cycles++;
          if (m_wait_cycles == TO) begin
            m_err = 1'b1;
            m_mode = M_REL;
          end
        end
        default: if (!m_lvl_before) m_mode = M_IDLE;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("go",   bus.go,   m_mode == M_ISSUE);
      check("busy", bus.busy, m_mode != M_IDLE);
      check("err",  bus.err,  m_err);
      check("op",   bus.op,   m_op);
      check("in1",  bus.in1,  m_in1);
      check("in2",  bus.in2,  m_in2);
      if (bus.go) begin
        go_count++;
        if (exp_q.size() == 0) begin
          check("go_unexpected", 1, 0);
        end else begin
          cmd_e = exp_q.pop_front();
          check("go_cmd", {bus.op, bus.in1, bus.in2}, cmd_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_go(input int bound, input string nm);
    int k = 0;
    while (!bus.go && k < bound) begin
      step(1);
      k++;
    end
    if (!bus.go) check(nm, 0, 1);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_go"},    bus.go,   0);
    check({nm, "_busy"},  bus.busy, 0);
    check({nm, "_err"},   bus.err,  0);
    check({nm, "_op"},    bus.op,   0);
    check({nm, "_in1"},   bus.in1,  0);
    check({nm, "_in2"},   bus.in2,  0);
    check({nm, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    int k;
    int gc0;
    int hold;
    bus.go_raw = 1'b0;
    bus.op_sw  = '0;
    bus.in1_sw = '0;
    bus.in2_sw = '0;
    bus.done   = 1'b0;
    rst_n = 1'b0;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Clean press from edge 10: go in the cycle after edge 10+2+DB = 16.
    while (cyc < 10) step(1);
    bus.op_sw = 2'b01; bus.in1_sw = 3'd3; bus.in2_sw = 3'd5;
    bus.go_raw = 1'b1;
    wait_go(30, "t1_wait_go");
    check("t1_go_edge", cyc, 16);
    check("t1_op", bus.op, 1);
    check("t1_in1", bus.in1, 3);
    check("t1_in2", bus.in2, 5);
    check("t1_busy", bus.busy, 1);

    // done pulse during WAIT while switches move; latched values must hold.
    step(2);
    bus.done = 1'b1;
    bus.op_sw = 2'b11; bus.in1_sw = 3'd7; bus.in2_sw = 3'd0;
    step(1);
    bus.done = 1'b0;
    step(1);
    check("t3_state_rel", dbg_state, ST_RELEASE);
    check("t3_err", bus.err, 0);
    check("t3_op_held", bus.op, 1);
    check("t3_in1_held", bus.in1, 3);
    check("t3_in2_held", bus.in2, 5);
    bus.go_raw = 1'b0;
    step(8);
    check("t3_state_idle", dbg_state, ST_IDLE);
    check("t3_busy", bus.busy, 0);

    // Bounce: toggling every 2 cycles never survives the debouncer.
    gc0 = go_count;
    for (int i = 0; i < 10; i++) begin
      bus.go_raw = ~bus.go_raw;
      step(2);
    end
    bus.go_raw = 1'b0;
    step(10);
    check("t2_no_go", go_count - gc0, 0);
    check("t2_idle", dbg_state, ST_IDLE);

    // Timeout: no done; err rises 16 WAIT cycles after the go cycle ends.
    bus.go_raw = 1'b1;
    wait_go(30, "t4_wait_go");
    g = cyc;
    k = 0;
    while (!bus.err && k < 40) begin
      step(1);
      k++;
    end
    check("t4_err_delay", cyc - g, TO + 1);
    bus.go_raw = 1'b0;
    step(10);
    check("t4_err_sticky", bus.err, 1);
    bus.op_sw = 2'b10; bus.in1_sw = 3'd6; bus.in2_sw = 3'd1;
    bus.go_raw = 1'b1;
    wait_go(30, "t4b_wait_go");
    check("t4_err_cleared", bus.err, 0);
    check("t4_op", bus.op, 2);
    step(2);
    bus.done = 1'b1;
    step(1);
    bus.done = 1'b0;
    bus.go_raw = 1'b0;
    step(10);

    // done already high before go is not a completion.
    bus.done = 1'b1;
    step(2);
    bus.go_raw = 1'b1;
    wait_go(30, "t5_wait_go");
    step(5);
    check("t5_still_wait", dbg_state, ST_WAIT);
    bus.done = 1'b0;
    step(2);
    bus.done = 1'b1;
    step(2);
    check("t5_completed", dbg_state, ST_RELEASE);
    check("t5_err", bus.err, 0);
    bus.done = 1'b0;
    bus.go_raw = 1'b0;
    step(10);

    // Async reset mid-WAIT, then mid-debounce with the button held.
    bus.go_raw = 1'b1;
    wait_go(30, "t6_wait_go");
    step(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst_wait");
    step(2);
    rst_n = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst_db");
    step(2);
    gc0 = go_count;
    rst_n = 1'b1;
    step(40);
    check("t6_one_go", go_count - gc0, 1);
    bus.go_raw = 1'b0;
    step(10);

    // Random presses, bounces, done activity and switch changes.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        bus.go_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) bus.done = ~bus.done;
      bus.op_sw  = 2'($urandom_range(0, 3));
      bus.in1_sw = 3'($urandom_range(0, 7));
      bus.in2_sw = 3'($urandom_range(0, 7));
      step(1);
    end

    bus.go_raw = 1'b0;
    bus.done = 1'b0;
    step(40);
    check("final_idle", dbg_state, ST_IDLE);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
